// File: rtl/assoc_matcher_pkg.sv
// Shared definitions for the associative exact-match lookup stage:
// bus widths, header geometry, the FSM state encoding, the lookup
// configuration record and the saturating counter increment.
package assoc_matcher_pkg;

  localparam int unsigned BYTE         = 8;
  localparam int unsigned DATA         = 32;
  localparam int unsigned ADDR         = 32;
  localparam int unsigned FLOW_TAG_LEN = 2;
  localparam int unsigned HDR_MAX_LEN  = 32;
  localparam int unsigned NUM_HEADERS  = 16;
  localparam int unsigned HASH_W       = 4;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HASH      = 4'd1,
    ST_HASH_WAIT = 4'd2,
    ST_RD_KEY    = 4'd3,
    ST_CMP       = 4'd4,
    ST_RD_VAL    = 4'd5,
    ST_WR_CNT    = 4'd6,
    ST_DONE      = 4'd7
  } state_t;

  typedef struct packed {
    logic [3:0]      hdr_id;
    logic [5:0]      key_off;
    logic [5:0]      key_len;
    logic [5:0]      val_len;
    logic [DATA-1:0] entry_len;
    logic [DATA-1:0] start_addr;
    logic [BYTE-1:0] tag;
    logic            is_counter;
  } cfg_t;

  function automatic logic [DATA-1:0] sat_inc(input logic [DATA-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/assoc_matcher_if.sv
// Word-wide shared-memory port of the matcher.
//   master: matcher side (drives enable/write/address/width/write data)
//   slave : memory side  (returns read data and a per-word ready)
interface assoc_matcher_if;
  import assoc_matcher_pkg::*;

  logic            mem_ce_o;
  logic            mem_we_o;
  logic [ADDR-1:0] mem_addr_o;
  logic [3:0]      mem_width_o;
  logic [DATA-1:0] mem_data_o;
  logic [DATA-1:0] mem_data_i;
  logic            mem_ready_i;

  modport master (
    output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    input  mem_data_i, mem_ready_i
  );

  modport slave (
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    output mem_data_i, mem_ready_i
  );
endinterface

// File: rtl/assoc_matcher_hash.sv
// Bucket hash with start/ready handshake.
//   start_i : latch a hash of key_i
//   key_i   : 64-bit {tag, 0, key...} vector
//   ready_o : one-cycle pulse, the cycle after start_i
//   hash_o  : bucket index, held until the next start_i
// The hash XOR-folds the eight key bytes, then folds the byte into a nibble.
module assoc_matcher_hash
  import assoc_matcher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [63:0]       key_i,
  output logic              ready_o,
  output logic [HASH_W-1:0] hash_o
);

  logic [7:0] fold8;

  always_comb begin
    fold8 = '0;
    for (int unsigned i = 0; i < 8; i++) fold8 = fold8 ^ key_i[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_o <= 1'b0;
      hash_o  <= '0;
    end else begin
      ready_o <= start_i;
      if (start_i) hash_o <= fold8[7:4] ^ fold8[3:0];
    end
  end

endmodule

// File: rtl/assoc_matcher.sv
// N-way set-associative exact-match lookup.
//   clk, rst (async, active low)
//   start_i / pkt_hdr_i / parsed_hdrs_i : lookup request and key source
//   mod_*                               : table configuration, loaded in IDLE
//   mem                                 : shared-memory word port (master)
//   busy_o, ready_o, is_match_o, hit_way_o, flow_val_o : lookup result
// Entry layout: KEY_WORDS big-endian words {tag, 0, key...}, then value words.
module assoc_matcher
  import assoc_matcher_pkg::*;
#(
  parameter int unsigned KEY_MAX_BYTES = 6,
  parameter int unsigned VAL_MAX_BYTES = 16,
  parameter int unsigned NUM_WAYS      = 2,
  parameter int unsigned WAY_W         = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [HDR_MAX_LEN-1:0][BYTE-1:0]      pkt_hdr_i,
  input  logic [NUM_HEADERS-1:0][DATA-1:0]      parsed_hdrs_i,
  input  logic                                  mod_start_i,
  input  logic [3:0]                            mod_hdr_id_i,
  input  logic [5:0]                            mod_key_off_i,
  input  logic [5:0]                            mod_key_len_i,
  input  logic [5:0]                            mod_val_len_i,
  input  logic [DATA-1:0]                       mod_entry_len_i,
  input  logic [DATA-1:0]                       mod_start_addr_i,
  input  logic [BYTE-1:0]                       mod_tag_i,
  input  logic                                  mod_counter_i,
  assoc_matcher_if.master                       mem,
  output logic                                  busy_o,
  output logic                                  ready_o,
  output logic                                  is_match_o,
  output logic [WAY_W-1:0]                      hit_way_o,
  output logic [VAL_MAX_BYTES-1:0][BYTE-1:0]    flow_val_o
);

  localparam int unsigned KEY_BYTES  = FLOW_TAG_LEN + KEY_MAX_BYTES;
  localparam int unsigned KEY_WORDS  = (KEY_BYTES + 3) / 4;
  localparam int unsigned VAL_WORDS  = VAL_MAX_BYTES / 4;
  localparam int unsigned HASH_BYTES = (KEY_BYTES < 8) ? KEY_BYTES : 8;
  localparam int unsigned HDR_IDX_W  = $clog2(HDR_MAX_LEN);
  localparam logic [7:0]       KEY_LAST = 8'(KEY_WORDS - 1);
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(NUM_WAYS - 1);

  state_t                              state_q;
  cfg_t                                cfg_q;
  logic [KEY_BYTES-1:0][BYTE-1:0]      key_c, key_q;
  logic [KEY_WORDS*4-1:0][BYTE-1:0]    rd_key_q;
  logic [WAY_W-1:0]                    way_q;
  logic [7:0]                          word_cnt_q;
  logic [DATA-1:0]                     entry_base_q, addr_q, first_entry, idx;
  logic [63:0]                         hash_vec;
  logic                                hash_ready, key_eq;
  logic [HASH_W-1:0]                   hash_val;
  logic [5:0]                          key_len_eff;
  logic [7:0]                          val_words, val_raw;

  // Key bytes: [0]=tag, [1]=0, [2+i]=header byte, masked by length and header bounds.
  always_comb begin
    key_len_eff = (cfg_q.key_len > 6'(KEY_MAX_BYTES)) ? 6'(KEY_MAX_BYTES) : cfg_q.key_len;
    key_c       = '0;
    key_c[0]    = cfg_q.tag;
    idx         = '0;
    for (int unsigned i = 0; i < KEY_MAX_BYTES; i++) begin
      idx = parsed_hdrs_i[cfg_q.hdr_id] + DATA'(cfg_q.key_off) + DATA'(i);
      if ((6'(i) < key_len_eff) && (idx < DATA'(HDR_MAX_LEN)))
        key_c[FLOW_TAG_LEN + i] = pkt_hdr_i[idx[HDR_IDX_W-1:0]];
    end
  end

  always_comb begin
    hash_vec = '0;
    for (int unsigned j = 0; j < HASH_BYTES; j++) hash_vec[63 - 8*j -: 8] = key_q[j];
  end

  assoc_matcher_hash u_hash (
    .clk     (clk),
    .rst     (rst),
    .start_i (state_q == ST_HASH),
    .key_i   (hash_vec),
    .ready_o (hash_ready),
    .hash_o  (hash_val)
  );

  always_comb begin
    key_eq = 1'b1;
    for (int unsigned j = 0; j < KEY_BYTES; j++)
      if (rd_key_q[j] != key_q[j]) key_eq = 1'b0;
  end

  always_comb begin
    val_raw     = 8'(cfg_q.val_len >> 2);
    val_words   = (val_raw > 8'(VAL_WORDS)) ? 8'(VAL_WORDS) : val_raw;
    first_entry = cfg_q.start_addr + (DATA'(hash_val) * DATA'(NUM_WAYS)) * cfg_q.entry_len;
  end

  assign mem.mem_ce_o    = (state_q == ST_RD_KEY) || (state_q == ST_RD_VAL) || (state_q == ST_WR_CNT);
  assign mem.mem_we_o    = (state_q == ST_WR_CNT);
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_width_o = 4'd4;
  assign mem.mem_data_o  = (state_q == ST_WR_CNT) ?
      sat_inc({flow_val_o[0], flow_val_o[1], flow_val_o[2], flow_val_o[3]}) : '0;

  assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign ready_o = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      key_q        <= '0;
      rd_key_q     <= '0;
      way_q        <= '0;
      word_cnt_q   <= '0;
      entry_base_q <= '0;
      addr_q       <= '0;
      is_match_o   <= 1'b0;
      hit_way_o    <= '0;
      flow_val_o   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mod_start_i) begin
            cfg_q <= '{hdr_id: mod_hdr_id_i, key_off: mod_key_off_i, key_len: mod_key_len_i,
                       val_len: mod_val_len_i, entry_len: mod_entry_len_i,
                       start_addr: mod_start_addr_i, tag: mod_tag_i, is_counter: mod_counter_i};
          end else if (start_i) begin
            key_q      <= key_c;
            is_match_o <= 1'b0;
            hit_way_o  <= '0;
            flow_val_o <= '0;
            way_q      <= '0;
            state_q    <= ST_HASH;
          end
        end
        ST_HASH: state_q <= ST_HASH_WAIT;
        ST_HASH_WAIT: begin
          if (hash_ready) begin
            entry_base_q <= first_entry;
            addr_q       <= first_entry;
            word_cnt_q   <= '0;
            state_q      <= ST_RD_KEY;
          end
        end
        ST_RD_KEY: begin
          if (mem.mem_ready_i) begin
            for (int unsigned k = 0; k < KEY_WORDS; k++)
              if (word_cnt_q == 8'(k))
                for (int unsigned b = 0; b < 4; b++)
                  rd_key_q[4*k + b] <= mem.mem_data_i[31 - 8*b -: 8];
            addr_q <= addr_q + 32'd4;
            if (word_cnt_q == KEY_LAST) begin
              word_cnt_q <= '0;
              state_q    <= ST_CMP;
            end else begin
              word_cnt_q <= word_cnt_q + 8'd1;
            end
          end
        end
        // On a hit addr_q already points at the value words of this entry.
        ST_CMP: begin
          if (key_eq) begin
            is_match_o <= 1'b1;
            hit_way_o  <= way_q;
            state_q    <= (val_words == 8'd0) ? ST_DONE : ST_RD_VAL;
          end else if (way_q == WAY_LAST) begin
            state_q <= ST_DONE;
          end else begin
            way_q        <= way_q + 1'b1;
            entry_base_q <= entry_base_q + cfg_q.entry_len;
            addr_q       <= entry_base_q + cfg_q.entry_len;
            state_q      <= ST_RD_KEY;
          end
        end
        ST_RD_VAL: begin
          if (mem.mem_ready_i) begin
            for (int unsigned k = 0; k < VAL_WORDS; k++)
              if (word_cnt_q == 8'(k))
                for (int unsigned b = 0; b < 4; b++)
                  flow_val_o[4*k + b] <= mem.mem_data_i[31 - 8*b -: 8];
            addr_q <= addr_q + 32'd4;
            if (word_cnt_q == val_words - 8'd1) begin
              word_cnt_q <= '0;
              if (cfg_q.is_counter) begin
                addr_q  <= entry_base_q + DATA'(KEY_WORDS * 4);
                state_q <= ST_WR_CNT;
              end else begin
                state_q <= ST_DONE;
              end
            end else begin
              word_cnt_q <= word_cnt_q + 8'd1;
            end
          end
        end
        ST_WR_CNT: if (mem.mem_ready_i) state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
